flash_seq: RTL

- Transaction sequencer directly upstream of the byte-serial flash shifter, which emits 8 FCK pulses per write strobe and presents the received byte on a read strobe.
- Runs one complete SPI flash transaction: asserts chip select, sends the opcode, sends 0 or 3 address bytes, then writes or reads N data bytes, and releases chip select.
- Sits between the VME register file (command/status) and the shifter; it is the only agent that drives the shifter strobes while the CPLD is flash master.

---
 rtl/flash_seq_pkg.sv | 30 +++
 rtl/flash_seq_timer.sv | 25 ++
 rtl/flash_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_seq_pkg.sv
// Shared constants and state encoding for the SPI flash transaction sequencer.
// BYTE_CYC_DEF is the byte-serial shifter's own timing and must track that block.
package flash_seq_pkg;

    localparam int BYTE_CYC_DEF = 17;
    localparam int CS_SETUP_DEF = 2;
    localparam int CS_HOLD_DEF  = 2;
    localparam int NMAX_W_DEF   = 9;
    localparam int TMR_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_SHIFT,
        ST_NEXT,
        ST_WFETCH,
        ST_HOLD
    } state_t;

    // Address bytes go out MSB first; 'left' counts down 3..1.
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] left);
        case (left)
            2'd3:    return addr[23:16];
            2'd2:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// Loadable down-counter with zero flag; shared by the SETUP, SHIFT and HOLD waits.
module flash_seq_timer #(
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/flash_seq.sv
// SPI flash transaction sequencer: chip select, opcode, optional 3-byte address,
// then N write or read data bytes, driving the byte-serial shifter strobes.
//
// state  | meaning
// IDLE   | waiting for START, chip select released
// SETUP  | chip select low, waiting before the first byte
// SEND   | FWS high for one cycle with FDO
// SHIFT  | shifter busy with the current byte
// NEXT   | byte boundary: FRS / RDATA capture, pick next byte
// WFETCH | WREQ high until WVALID supplies a write byte
// HOLD   | last byte done, waiting before releasing chip select
module flash_seq
    import flash_seq_pkg::*;
#(
    parameter int BYTE_CYC = BYTE_CYC_DEF,
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF,
    parameter int NMAX_W   = NMAX_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              ABORT,
    input  logic [7:0]        OPCODE,
    input  logic [23:0]       ADDR,
    input  logic              ADDR_EN,
    input  logic              DIR_RD,
    input  logic [NMAX_W-1:0] NBYTES,
    input  logic [7:0]        WDATA,
    input  logic              WVALID,
    output logic              WREQ,
    output logic [7:0]        RDATA,
    output logic              RVALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              FCS_N,
    output logic              FWS,
    output logic [7:0]        FDO,
    output logic              FRS,
    input  logic [7:0]        FDI
);

    localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] TMR_SHIFT = TMR_W'(BYTE_CYC - 2);
    localparam logic [TMR_W-1:0] TMR_HOLD  = TMR_W'(CS_HOLD - 1);

    state_t            state;
    logic [7:0]        opcode_q;
    logic [23:0]       addr_q;
    logic              dir_rd_q;
    logic [1:0]        addr_left;
    logic [NMAX_W-1:0] data_left;
    logic              cur_rd;
    logic              abort_q;
    logic              abort_any;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

    assign abort_any = ABORT | abort_q;

    // The timer is reloaded every cycle of the state preceding each wait, so the
    // wait starts counting on the exact cycle its state is entered.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMR_HOLD;
        case (state)
            ST_IDLE:   begin tmr_load = 1'b1; tmr_val = TMR_SETUP; end
            ST_SEND:   begin tmr_load = 1'b1; tmr_val = TMR_SHIFT; end
            ST_NEXT,
            ST_WFETCH: tmr_load = 1'b1;
            default:   tmr_load = 1'b0;
        endcase
    end

    flash_seq_timer #(.W(TMR_W)) u_timer (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            FCS_N     <= 1'b1;
            FWS       <= 1'b0;
            FRS       <= 1'b0;
            WREQ      <= 1'b0;
            RVALID    <= 1'b0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
            FDO       <= 8'h00;
            RDATA     <= 8'h00;
            opcode_q  <= 8'h00;
            addr_q    <= 24'h0;
            dir_rd_q  <= 1'b0;
            addr_left <= 2'd0;
            data_left <= '0;
            cur_rd    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            FWS    <= 1'b0;
            FRS    <= 1'b0;
            WREQ   <= 1'b0;
            RVALID <= 1'b0;
            DONE   <= 1'b0;
            if (state != ST_IDLE && ABORT)
                abort_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (START && !ABORT) begin
                        opcode_q  <= OPCODE;
                        addr_q    <= ADDR;
                        dir_rd_q  <= DIR_RD;
                        addr_left <= ADDR_EN ? 2'd3 : 2'd0;
                        data_left <= NBYTES;
                        BUSY      <= 1'b1;
                        FCS_N     <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        if (abort_any) begin
                            state <= ST_NEXT;
                        end else begin
                            FWS    <= 1'b1;
                            FDO    <= opcode_q;
                            cur_rd <= 1'b0;
                            state  <= ST_SEND;
                        end
                    end
                end
                ST_SEND: state <= ST_SHIFT;
                ST_SHIFT: begin
                    // Write data is requested one cycle early so an unstalled
                    // write keeps the same FWS pitch as a read.
                    if (tmr_zero) begin
                        if (!abort_any && addr_left == 2'd0 && data_left != '0 && !dir_rd_q) begin
                            WREQ  <= 1'b1;
                            state <= ST_WFETCH;
                        end else begin
                            FRS   <= cur_rd;
                            state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (FRS) begin
                        RDATA  <= FDI;
                        RVALID <= 1'b1;
                    end
                    if (abort_any) begin
                        state <= ST_HOLD;
                    end else if (addr_left != 2'd0) begin
                        FWS       <= 1'b1;
                        FDO       <= addr_byte(addr_q, addr_left);
                        addr_left <= addr_left - 2'd1;
                        cur_rd    <= 1'b0;
                        state     <= ST_SEND;
                    end else if (data_left != '0 && dir_rd_q) begin
                        FWS       <= 1'b1;
                        FDO       <= 8'h00;
                        data_left <= data_left - 1'b1;
                        cur_rd    <= 1'b1;
                        state     <= ST_SEND;
                    end else if (data_left != '0) begin
                        WREQ  <= 1'b1;
                        state <= ST_WFETCH;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                ST_WFETCH: begin
                    if (abort_any) begin
                        state <= ST_HOLD;
                    end else if (WVALID) begin
                        FWS       <= 1'b1;
                        FDO       <= WDATA;
                        data_left <= data_left - 1'b1;
                        cur_rd    <= 1'b0;
                        state     <= ST_SEND;
                    end else begin
                        WREQ <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        FCS_N <= 1'b1;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
